// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode/function, ALU and select encodings for the multicycle MIPS control.
package mips_ctrl_pkg;
  localparam int ALU_OP_BITS = 4;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

  typedef enum logic [ALU_OP_BITS-1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [3:0] {
    CL_NOP, CL_RALU, CL_IALU, CL_LW, CL_SW, CL_BR, CL_J, CL_JAL, CL_JR
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23,
                         OP_SW = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08,
                         FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25,
                         FN_XOR = 6'h26, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [1:0] PC_SRC_PC4 = 2'd0, PC_SRC_BR = 2'd1, PC_SRC_JMP = 2'd2, PC_SRC_RS = 2'd3;
  localparam logic [1:0] SRCB_RT = 2'd0, SRCB_4 = 2'd1, SRCB_SEXT = 2'd2, SRCB_ZEXT = 2'd3;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] M2R_ALU = 2'd0, M2R_MDR = 2'd1, M2R_PC4 = 2'd2;
endpackage

// File: rtl/mips_multicycle_ctrl_op_decode.sv
// mips_ctrl_op_decode: maps op_code/fn_code to instruction class, ALU op, EXEC B-operand and a supported flag.
module mips_ctrl_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] fn_code,
  output cls_e       cls,
  output alu_op_e    alu_op,
  output logic [1:0] alu_src_b,
  output logic       supported
);
  always_comb begin
    cls = CL_NOP;
    alu_op = ALU_ADD;
    alu_src_b = SRCB_RT;
    case (op_code)
      OP_RTYPE: begin
        cls = CL_RALU;
        case (fn_code)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_JR:   cls = CL_JR;
          default: cls = CL_NOP;
        endcase
      end
      OP_ADDIU: begin cls = CL_IALU; alu_src_b = SRCB_SEXT; end
      OP_SLTI:  begin cls = CL_IALU; alu_src_b = SRCB_SEXT; alu_op = ALU_SLT; end
      OP_ANDI:  begin cls = CL_IALU; alu_src_b = SRCB_ZEXT; alu_op = ALU_AND; end
      OP_ORI:   begin cls = CL_IALU; alu_src_b = SRCB_ZEXT; alu_op = ALU_OR; end
      OP_XORI:  begin cls = CL_IALU; alu_src_b = SRCB_ZEXT; alu_op = ALU_XOR; end
      OP_LUI:   begin cls = CL_IALU; alu_src_b = SRCB_ZEXT; alu_op = ALU_LUI; end
      OP_LW:    begin cls = CL_LW; alu_src_b = SRCB_SEXT; end
      OP_SW:    begin cls = CL_SW; alu_src_b = SRCB_SEXT; end
      OP_BEQ, OP_BNE: begin cls = CL_BR; alu_op = ALU_SUB; end
      OP_J:     cls = CL_J;
      OP_JAL:   cls = CL_JAL;
      default:  cls = CL_NOP;
    endcase
    supported = cls != CL_NOP;
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with halt detection.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to trap unsupported encodings into HALT with a sticky illegal flag.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5:0]          op_code,
  input  logic [5:0]          fn_code,
  input  logic                alu_zero,
  input  logic                pc_next_zero,
  input  logic                mem_waitrequest,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                active,
  output logic                illegal
);
  state_e     state_q, state_d;
  cls_e       cls;
  alu_op_e    dec_op, alu_op_c;
  logic [1:0] dec_src_b;
  logic       supported;
  logic       is_jump;

  mips_ctrl_op_decode u_dec (
    .op_code  (op_code),
    .fn_code  (fn_code),
    .cls      (cls),
    .alu_op   (dec_op),
    .alu_src_b(dec_src_b),
    .supported(supported)
  );

  assign is_jump = cls == CL_J || cls == CL_JAL || cls == CL_JR;
  assign alu_op = ALU_OP_W'(alu_op_c);
  assign active = state_q != HALT;

  // Everything is gated by reset_n so an in-flight request drops the moment reset asserts.
  always_comb begin
    state_d = state_q;
    mem_read = 1'b0;
    mem_write = 1'b0;
    i_or_d = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = PC_SRC_PC4;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RT;
    alu_op_c = ALU_ADD;
    reg_write = 1'b0;
    reg_dst = DST_RT;
    mem_to_reg = M2R_ALU;
    if (reset_n) begin
      case (state_q)
        FETCH: begin
          mem_read = 1'b1;
          alu_src_b = SRCB_4;
          ir_write = !mem_waitrequest;
          pc_write = !mem_waitrequest;
          state_d = mem_waitrequest ? FETCH : DECODE;
        end
        DECODE: begin
          alu_src_b = SRCB_SEXT;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          state_d = supported ? EXEC : HALT;
`else
          state_d = supported ? EXEC : FETCH;
`endif
        end
        EXEC: begin
          alu_src_a = !is_jump;
          alu_src_b = dec_src_b;
          alu_op_c = dec_op;
          pc_write = cls == CL_BR ? (alu_zero ~^ (op_code == OP_BEQ)) : is_jump;
          pc_src = cls == CL_BR ? PC_SRC_BR : cls == CL_JR ? PC_SRC_RS : is_jump ? PC_SRC_JMP : PC_SRC_PC4;
          reg_write = cls == CL_JAL;
          reg_dst = cls == CL_JAL ? DST_RA : DST_RT;
          mem_to_reg = cls == CL_JAL ? M2R_PC4 : M2R_ALU;
          state_d = (cls == CL_LW || cls == CL_SW) ? MEM : (cls == CL_RALU || cls == CL_IALU) ? WB : FETCH;
        end
        MEM: begin
          mem_read = cls == CL_LW;
          mem_write = cls == CL_SW;
          i_or_d = 1'b1;
          state_d = mem_waitrequest ? MEM : cls == CL_LW ? WB : FETCH;
        end
        WB: begin
          reg_write = 1'b1;
          reg_dst = cls == CL_RALU ? DST_RD : DST_RT;
          mem_to_reg = cls == CL_LW ? M2R_MDR : M2R_ALU;
          state_d = FETCH;
        end
        default: state_d = HALT;
      endcase
      if (pc_write && pc_next_zero) state_d = HALT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else state_q <= state_d;
  end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) illegal_q <= 1'b0;
    else illegal_q <= illegal_q | (state_q == DECODE && !supported);
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif
endmodule
